s208_y_counter: RTL and testbench



---
 rtl/s208_y_counter_if.sv | 26 ++
 rtl/s208_y_counter.sv | 104 ++++++++++
 tb/tb_s208_y_counter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/s208_y_counter_if.sv
// Handshake and output bundle for the s208 counter/coefficient stage.
// The master drives count control and coefficient words; the slave returns Y, C, C_READY and WRAP.
interface s208_y_counter_if;
   logic       X;
   logic       CLR;
   logic [8:0] C_IN;
   logic       C_VALID;
   logic       C_READY;
   logic       Y_1, Y_2, Y_3, Y_4, Y_5, Y_6, Y_7, Y_8;
   logic       C_0, C_1, C_2, C_3, C_4, C_5, C_6, C_7, C_8;
   logic       WRAP;

   modport master (
      output X, CLR, C_IN, C_VALID,
      input  C_READY, WRAP,
      input  Y_1, Y_2, Y_3, Y_4, Y_5, Y_6, Y_7, Y_8,
      input  C_0, C_1, C_2, C_3, C_4, C_5, C_6, C_7, C_8
   );

   modport slave (
      input  X, CLR, C_IN, C_VALID,
      output C_READY, WRAP,
      output Y_1, Y_2, Y_3, Y_4, Y_5, Y_6, Y_7, Y_8,
      output C_0, C_1, C_2, C_3, C_4, C_5, C_6, C_7, C_8
   );
endinterface

// File: rtl/s208_y_counter.sv
// 8-bit up-counter with a shadowed coefficient register for the s208 rate multiplier.
// Coefficients only take effect at a wrap or clear, so a rate change never splits a period.
module s208_y_counter (
   input  logic                  CK,
   input  logic                  RN,
   s208_y_counter_if.slave       bus
);

   logic [7:0] count_r,   count_nxt_s;
   logic [8:0] coef_r,    coef_nxt_s;
   logic [8:0] shadow_r,  shadow_nxt_s;
   logic       pending_r, pending_nxt_s;
   logic       ready_r,   ready_nxt_s;
   logic       wrap_r,    wrap_nxt_s;

   logic       wrap_edge_s;
   logic       apply_s;
   logic       transfer_s;

   // Next-state evaluation for counter, handshake and coefficient apply.
   always_comb begin
      count_nxt_s   = count_r;
      coef_nxt_s    = coef_r;
      shadow_nxt_s  = shadow_r;
      pending_nxt_s = pending_r;
      wrap_edge_s   = 1'b0;
      apply_s       = 1'b0;
      transfer_s    = 1'b0;

      wrap_edge_s = (~bus.CLR) & bus.X & (count_r == 8'hFF);
      apply_s     = bus.CLR | wrap_edge_s;
      transfer_s  = bus.C_VALID & ready_r;

      if (bus.CLR) begin
         count_nxt_s = 8'h00;
      end else if (bus.X) begin
         count_nxt_s = count_r + 8'h01;
      end else begin
         count_nxt_s = count_r;
      end

      // A transfer coinciding with an apply bypasses the shadow entirely.
      if (apply_s) begin
         pending_nxt_s = 1'b0;
         if (pending_r) begin
            coef_nxt_s = shadow_r;
         end else if (transfer_s) begin
            coef_nxt_s = bus.C_IN;
         end else begin
            coef_nxt_s = coef_r;
         end
      end else if (transfer_s) begin
         shadow_nxt_s  = bus.C_IN;
         pending_nxt_s = 1'b1;
      end else begin
         pending_nxt_s = pending_r;
      end

      ready_nxt_s = ~pending_nxt_s;
      wrap_nxt_s  = wrap_edge_s;
   end

   // State registers; reset clears everything including a WRAP pulse in flight.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         count_r   <= 8'h00;
         coef_r    <= 9'h000;
         shadow_r  <= 9'h000;
         pending_r <= 1'b0;
         ready_r   <= 1'b1;
         wrap_r    <= 1'b0;
      end else begin
         count_r   <= count_nxt_s;
         coef_r    <= coef_nxt_s;
         shadow_r  <= shadow_nxt_s;
         pending_r <= pending_nxt_s;
         ready_r   <= ready_nxt_s;
         wrap_r    <= wrap_nxt_s;
      end
   end

   assign bus.C_READY = ready_r;
   assign bus.WRAP    = wrap_r;

   assign bus.Y_1 = count_r[0];
   assign bus.Y_2 = count_r[1];
   assign bus.Y_3 = count_r[2];
   assign bus.Y_4 = count_r[3];
   assign bus.Y_5 = count_r[4];
   assign bus.Y_6 = count_r[5];
   assign bus.Y_7 = count_r[6];
   assign bus.Y_8 = count_r[7];

   assign bus.C_0 = coef_r[0];
   assign bus.C_1 = coef_r[1];
   assign bus.C_2 = coef_r[2];
   assign bus.C_3 = coef_r[3];
   assign bus.C_4 = coef_r[4];
   assign bus.C_5 = coef_r[5];
   assign bus.C_6 = coef_r[6];
   assign bus.C_7 = coef_r[7];
   assign bus.C_8 = coef_r[8];

endmodule

// File: tb/tb_s208_y_counter.sv
// Directed and randomized checks of s208_y_counter against a queue-based behavioural model.
module tb_s208_y_counter;

   logic ck;
   logic rn;
   s208_y_counter_if bus ();

   s208_y_counter dut (
      .CK  (ck),
      .RN  (rn),
      .bus (bus)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   int         vectors = 0;
   int         miscompares = 0;

   // Reference model: count as an integer, pending coefficient as a 0/1-entry queue.
   int         m_y;
   logic [8:0] m_c;
   logic       m_wrap;
   logic [8:0] m_q[$];

   function automatic logic [18:0] dut_obs();
      return {bus.Y_8, bus.Y_7, bus.Y_6, bus.Y_5, bus.Y_4, bus.Y_3, bus.Y_2, bus.Y_1,
              bus.C_8, bus.C_7, bus.C_6, bus.C_5, bus.C_4, bus.C_3, bus.C_2, bus.C_1, bus.C_0,
              bus.C_READY, bus.WRAP};
   endfunction

   function automatic logic [18:0] model_obs();
      logic [7:0] y8;
      y8 = m_y[7:0];
      return {y8, m_c, (m_q.size() == 0), m_wrap};
   endfunction

   task automatic model_reset();
      m_y = 0;
      m_c = 9'h000;
      m_wrap = 1'b0;
      m_q.delete();
   endtask

   task automatic check(input string tag, input logic [18:0] exp);
      logic [18:0] obs;
      obs = dut_obs();
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed Y=%0d C=%h RDY=%b WRAP=%b expected Y=%0d C=%h RDY=%b WRAP=%b",
                tag, obs[18:11], obs[10:2], obs[1], obs[0], exp[18:11], exp[10:2], exp[1], exp[0]);
      end
   endtask

   // One clock edge: drive inputs, advance the model by the behavioural rules, compare.
   task automatic step(input logic x, input logic clr, input logic v, input logic [8:0] cin,
                       input string tag);
      bit ready, transfer, wrap_edge, apply;
      bus.X = x; bus.CLR = clr; bus.C_VALID = v; bus.C_IN = cin;
      @(posedge ck);
      ready     = (m_q.size() == 0);
      transfer  = v && ready;
      wrap_edge = !clr && x && (m_y == 255);
      apply     = clr || wrap_edge;
      if (apply) begin
         if (m_q.size() != 0) m_c = m_q.pop_front();
         else if (transfer)   m_c = cin;
      end else if (transfer) begin
         m_q.push_back(cin);
      end
      m_y    = clr ? 0 : (x ? (m_y + 1) % 256 : m_y);
      m_wrap = wrap_edge;
      #1;
      check(tag, model_obs());
   endtask

   task automatic run_to(input int target, input logic v, input logic [8:0] cin, input string tag);
      int n;
      n = 0;
      while (m_y != target && n < 600) begin
         step(1'b1, 1'b0, v, cin, tag);
         n++;
      end
      if (m_y != target) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: timeout, model Y=%0d required %0d", tag, m_y, target);
      end
   endtask

   initial begin
      logic [8:0] rcin;
      logic       rx, rclr, rv;

      rn = 1'b0;
      bus.X = 1'b0; bus.CLR = 1'b0; bus.C_VALID = 1'b0; bus.C_IN = 9'h000;
      model_reset();
      @(posedge ck); #1;
      check("reset", {8'd0, 9'h000, 1'b1, 1'b0});
      @(negedge ck);
      rn = 1'b1;

      // Full period with no coefficient traffic.
      for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b0, 9'h000, "free_run");
      check("free_run_end", {8'd0, 9'h000, 1'b1, 1'b1});

      // Transfer at Y=10, visible only after the wrap.
      run_to(10, 1'b0, 9'h000, "to10");
      step(1'b1, 1'b0, 1'b1, 9'h1FF, "xfer_1ff");
      check("ready_low", {8'd11, 9'h000, 1'b0, 1'b0});
      run_to(0, 1'b0, 9'h000, "wait_wrap");
      check("apply_1ff", {8'd0, 9'h1FF, 1'b1, 1'b1});

      // Transfer on the wrap edge itself.
      run_to(255, 1'b0, 9'h000, "to255");
      step(1'b1, 1'b0, 1'b1, 9'h0AA, "xfer_on_wrap");
      check("direct_0aa", {8'd0, 9'h0AA, 1'b1, 1'b1});

      // Pending 0x155 applied by CLR at Y=77 while 0x003 waits.
      run_to(70, 1'b0, 9'h000, "to70");
      step(1'b1, 1'b0, 1'b1, 9'h155, "xfer_155");
      run_to(77, 1'b1, 9'h003, "hold_003");
      step(1'b1, 1'b1, 1'b1, 9'h003, "clr_apply");
      check("clr_155", {8'd0, 9'h155, 1'b1, 1'b0});
      step(1'b1, 1'b0, 1'b1, 9'h003, "accept_003");
      check("pending_003", {8'd1, 9'h155, 1'b0, 1'b0});

      // X toggling, then CLR at Y=255 with X=1 suppresses WRAP and applies 0x003.
      run_to(248, 1'b0, 9'h000, "to248");
      while (m_y != 255) begin
         step(1'b1, 1'b0, 1'b0, 9'h000, "toggle_x1");
         step(1'b0, 1'b0, 1'b0, 9'h000, "toggle_x0");
      end
      step(1'b1, 1'b1, 1'b0, 9'h000, "clr_at_255");
      check("clr_no_wrap", {8'd0, 9'h003, 1'b1, 1'b0});

      // Asynchronous reset mid-period with a coefficient pending.
      run_to(190, 1'b0, 9'h000, "to190");
      step(1'b1, 1'b0, 1'b1, 9'h0F0, "xfer_0f0");
      run_to(200, 1'b0, 9'h000, "to200");
      @(negedge ck);
      rn = 1'b0;
      #1;
      model_reset();
      check("async_reset", {8'd0, 9'h000, 1'b1, 1'b0});
      #3;
      rn = 1'b1;

      // Randomized traffic; C_IN only changes while nothing is pending.
      rcin = 9'h000;
      for (int i = 0; i < 3000; i++) begin
         rx   = ($urandom_range(0, 3) != 0);
         rclr = ($urandom_range(0, 99) == 0);
         rv   = $urandom_range(0, 1);
         if (m_q.size() == 0) rcin = 9'($urandom_range(0, 511));
         step(rx, rclr, rv, rcin, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
